// File: rtl/tamagotchi_stats.sv
// tamagotchi_stats: game-state engine producing the six 3-bit display values
// (food, sleep, fun, happiness, health, life-cycle state) plus the game tick.
module tamagotchi_stats #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned FOOD_DECAY  = 4,
  parameter int unsigned FUN_DECAY   = 3,
  parameter int unsigned SLEEP_DECAY = 5,
  parameter int unsigned SLEEP_GAIN  = 2,
  parameter int unsigned SICK_DECAY  = 2,
  parameter int unsigned BTN_GAIN    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_feed,
  input  logic       btn_sleep,
  input  logic       btn_play,
  input  logic       btn_heal,
  output logic [2:0] foodValue,
  output logic [2:0] sleepValue,
  output logic [2:0] funValue,
  output logic [2:0] happyValue,
  output logic [2:0] healthValue,
  output logic [2:0] testValue,
  output logic       tick
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = 8;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    GAIN      = 4'(BTN_GAIN);

  typedef enum logic [1:0] {
    AWAKE  = 2'd0,
    ASLEEP = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] div_cnt, div_nxt;
  logic [DW-1:0] food_cnt, fun_cnt, sdec_cnt, sgain_cnt, sick_cnt;
  logic [DW-1:0] food_cnt_nxt, fun_cnt_nxt, sdec_cnt_nxt, sgain_cnt_nxt, sick_cnt_nxt;
  logic          feed_q, sleep_q, play_q, heal_q;
  logic          alive, awake, asleep, sick;
  logic          feed_ev, sleep_ev, play_ev, heal_ev;
  logic          food_step, fun_step, sdec_step, sgain_step, sick_step;
  logic [2:0]    food_nxt, sleep_nxt, fun_nxt, health_nxt;
  logic [3:0]    happy_sum;

  // Saturating 0..7 update: cur + gain - step evaluated in 4 bits.
  function automatic logic [2:0] stat_next(input logic [2:0] cur, input logic [3:0] gain,
                                           input logic step);
    logic [3:0] sum;
    sum = {1'b0, cur} + gain;
    if (step) sum = (sum == 4'd0) ? 4'd0 : sum - 4'd1;
    return (sum > 4'd7) ? 3'd7 : sum[2:0];
  endfunction

  // Period counter: advances when enabled, wraps at period-1.
  function automatic logic [DW-1:0] cnt_next(input logic [DW-1:0] cnt, input logic en,
                                             input int unsigned period);
    if (!en) return cnt;
    return (cnt == DW'(period - 1)) ? '0 : cnt + DW'(1);
  endfunction

  // Action qualification, decay strobes and next stat values.
  always_comb begin
    alive      = (state != DEAD) && (healthValue != 3'd0);
    awake      = alive && (state == AWAKE);
    asleep     = alive && (state == ASLEEP);
    sick       = (foodValue == 3'd0) || (sleepValue == 3'd0) || (funValue == 3'd0);
    div_nxt    = (div_cnt == TICK_LAST) ? '0 : div_cnt + TW'(1);

    feed_ev    = btn_feed  & ~feed_q  & awake;
    play_ev    = btn_play  & ~play_q  & awake;
    heal_ev    = btn_heal  & ~heal_q  & alive;
    sleep_ev   = btn_sleep & ~sleep_q & alive;

    food_step  = tick && alive  && (food_cnt  == DW'(FOOD_DECAY - 1));
    fun_step   = tick && awake  && (fun_cnt   == DW'(FUN_DECAY - 1));
    sdec_step  = tick && awake  && (sdec_cnt  == DW'(SLEEP_DECAY - 1));
    sgain_step = tick && asleep && (sgain_cnt == DW'(SLEEP_GAIN - 1));
    sick_step  = tick && alive  && sick && (sick_cnt == DW'(SICK_DECAY - 1));

    food_cnt_nxt  = cnt_next(food_cnt,  tick && alive,  FOOD_DECAY);
    fun_cnt_nxt   = cnt_next(fun_cnt,   tick && awake,  FUN_DECAY);
    sdec_cnt_nxt  = cnt_next(sdec_cnt,  tick && awake,  SLEEP_DECAY);
    sgain_cnt_nxt = cnt_next(sgain_cnt, tick && asleep, SLEEP_GAIN);
    sick_cnt_nxt  = sick ? cnt_next(sick_cnt, tick && alive, SICK_DECAY) : '0;

    food_nxt   = stat_next(foodValue,   feed_ev ? GAIN : 4'd0, food_step);
    fun_nxt    = stat_next(funValue,    play_ev ? GAIN : 4'd0, fun_step);
    sleep_nxt  = stat_next(sleepValue,  {3'b000, sgain_step},  sdec_step);
    health_nxt = stat_next(healthValue, heal_ev ? GAIN : 4'd0, sick_step);
    happy_sum  = {1'b0, foodValue} + {1'b0, funValue};
  end

  // Game-tick divider; tick is high while the divider sits at its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      tick    <= (div_nxt == TICK_LAST);
    end
  end

  // Decay counters and button edge registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      food_cnt  <= '0;
      fun_cnt   <= '0;
      sdec_cnt  <= '0;
      sgain_cnt <= '0;
      sick_cnt  <= '0;
      feed_q    <= 1'b0;
      sleep_q   <= 1'b0;
      play_q    <= 1'b0;
      heal_q    <= 1'b0;
    end else begin
      food_cnt  <= food_cnt_nxt;
      fun_cnt   <= fun_cnt_nxt;
      sdec_cnt  <= sdec_cnt_nxt;
      sgain_cnt <= sgain_cnt_nxt;
      sick_cnt  <= sick_cnt_nxt;
      feed_q    <= btn_feed;
      sleep_q   <= btn_sleep;
      play_q    <= btn_play;
      heal_q    <= btn_heal;
    end
  end

  // Stat registers; happiness lags food/fun by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      foodValue   <= 3'd7;
      sleepValue  <= 3'd7;
      funValue    <= 3'd7;
      healthValue <= 3'd7;
      happyValue  <= 3'd7;
    end else begin
      foodValue   <= food_nxt;
      sleepValue  <= sleep_nxt;
      funValue    <= fun_nxt;
      healthValue <= health_nxt;
      happyValue  <= happy_sum[3:1];
    end
  end

  // Life-cycle FSM; zero health overrides any button, DEAD exits only via rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= AWAKE;
      testValue <= 3'd0;
    end else if ((state != DEAD) && (healthValue == 3'd0)) begin
      state     <= DEAD;
      testValue <= 3'd2;
    end else begin
      case (state)
        AWAKE: begin
          if (sleep_ev) begin
            state     <= ASLEEP;
            testValue <= 3'd1;
          end
        end
        ASLEEP: begin
          if (sleep_ev || (sleepValue == 3'd7)) begin
            state     <= AWAKE;
            testValue <= 3'd0;
          end
        end
        DEAD: begin
          state     <= DEAD;
          testValue <= 3'd2;
        end
        default: begin
          state     <= AWAKE;
          testValue <= 3'd0;
        end
      endcase
    end
  end

endmodule
